// File: rtl/alk_qseq.sv
// alk_qseq: sequenced Q register with multi-step left/right shifts over a
// selectable field (byte/word/long/quad), with shift-in and shift-out routed
// through open-drain Q_SIO pad taps at bits {63,31,15,7,0}.
// Optional feature macro: ALK_QSEQ_ROTATE_EN (adds rot_h; internal rotate
// that keeps the pads released).
//
// Handshake: start_h is accepted only in IDLE and latches dsize_h, dir_shr_h
// and step_cnt_h (plus rot_h when built in). busy_h is high for exactly one
// cycle per step. done_h pulses for the single cycle after the final step.
// start_h and q_load_h are ignored while busy_h or done_h is high.
module alk_qseq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic              clk_h,
    input  logic              reset_h,
    input  logic [1:0]        dsize_h,
    input  logic              q_load_h,
    input  logic [DATA_W-1:0] q_load_data_h,
    input  logic              start_h,
    input  logic              dir_shr_h,
    input  logic [CNT_W-1:0]  step_cnt_h,
`ifdef ALK_QSEQ_ROTATE_EN
    input  logic              rot_h,
`endif
    output logic              busy_h,
    output logic              done_h,
    output logic [DATA_W-1:0] q_h,
    input  logic [4:0]        q_sio_in_l,
    output logic [4:0]        q_sio_out_l
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        size_q;
    logic              dir_q;
    logic              rot_q;

    // Size decode, shift data and pad values
    logic [1:0]        dsize_eff;
    logic [DATA_W-1:0] field_mask;
    logic [DATA_W-1:0] msb_hot;
    logic [2:0]        msb_tap;
    logic              out_bit;
    logic              in_bit;
    logic [2:0]        in_tap;
    logic [2:0]        out_tap;
    logic [DATA_W-1:0] q_shift;

    // With a 32-bit Q the quad size collapses to long everywhere
    assign dsize_eff = (DATA_W == 32 && dsize_h == 2'b11) ? 2'b10 : dsize_h;

    // Active field mask, its msb one-hot and the pad tap serving that msb
    always_comb begin
        field_mask = '1;
        msb_hot    = DATA_W'(64'h8000_0000_0000_0000);
        msb_tap    = 3'd4;
        case (size_q)
            2'b00: begin
                field_mask = DATA_W'(64'h0000_0000_0000_00FF);
                msb_hot    = DATA_W'(64'h0000_0000_0000_0080);
                msb_tap    = 3'd1;
            end
            2'b01: begin
                field_mask = DATA_W'(64'h0000_0000_0000_FFFF);
                msb_hot    = DATA_W'(64'h0000_0000_0000_8000);
                msb_tap    = 3'd2;
            end
            2'b10: begin
                field_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
                msb_hot    = DATA_W'(64'h0000_0000_8000_0000);
                msb_tap    = 3'd3;
            end
            default: begin
                field_mask = '1;
                msb_hot    = DATA_W'(64'h8000_0000_0000_0000);
                msb_tap    = 3'd4;
            end
        endcase
    end

    // One shift step of the active field; bits above the field are held
    always_comb begin
        out_bit = dir_q ? q[0] : |(q & msb_hot);
        in_tap  = dir_q ? msb_tap : 3'd0;
        out_tap = dir_q ? 3'd0 : msb_tap;
        in_bit  = rot_q ? out_bit : ~q_sio_in_l[in_tap];
        if (dir_q) begin
            q_shift = (q & ~field_mask) | ((q & field_mask) >> 1)
                    | (in_bit ? msb_hot : '0);
        end else begin
            q_shift = (q & ~field_mask) | ((q << 1) & field_mask)
                    | DATA_W'(in_bit);
        end
    end

    // Open-drain pad drive: only the shift-out tap, only while running
    always_comb begin
        q_sio_out_l = 5'b11111;
        if (state == S_RUN && !rot_q) begin
            q_sio_out_l[out_tap] = ~out_bit;
        end
    end

    // State register
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_h) state_nx = S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Q, step counter and latched controls
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            q      <= '0;
            cnt    <= '0;
            size_q <= 2'b00;
            dir_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (q_load_h) q <= q_load_data_h;
                    if (start_h) begin
                        size_q <= dsize_eff;
                        dir_q  <= dir_shr_h;
                        cnt    <= (step_cnt_h == '0) ? CNT_W'(DATA_W) : step_cnt_h;
                    end
                end
                S_RUN: begin
                    q   <= q_shift;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ALK_QSEQ_ROTATE_EN
    // Rotate mode latched with the other controls
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            rot_q <= 1'b0;
        end else if (state == S_IDLE && start_h) begin
            rot_q <= rot_h;
        end
    end
`else
    assign rot_q = 1'b0;
`endif

    assign busy_h = (state == S_RUN);
    assign done_h = (state == S_DONE);
    assign q_h    = q;

endmodule

// File: tb/tb_alk_qseq.sv
// Bench for alk_qseq: a 32-bit and a 64-bit instance share one stimulus
// stream and are checked every cycle against a step-level model.
module tb_alk_qseq;

  logic        clk_h = 1'b0;
  logic        reset_h;
  logic [1:0]  dsize_h;
  logic        q_load_h;
  logic [63:0] ld_data;
  logic        start_h;
  logic        dir_shr_h;
  logic [6:0]  step_cnt_h;
  logic [4:0]  q_sio_in_l;
  logic        rot_h;

  logic        busy32, done32, busy64, done64;
  logic [31:0] q32;
  logic [63:0] q64;
  logic [4:0]  out32, out64;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- clock ----------------
  always #5 clk_h = ~clk_h;

  alk_qseq #(.DATA_W(32), .CNT_W(7)) dut32 (
    .clk_h(clk_h), .reset_h(reset_h), .dsize_h(dsize_h), .q_load_h(q_load_h),
    .q_load_data_h(ld_data[31:0]), .start_h(start_h), .dir_shr_h(dir_shr_h),
    .step_cnt_h(step_cnt_h),
`ifdef ALK_QSEQ_ROTATE_EN
    .rot_h(rot_h),
`endif
    .busy_h(busy32), .done_h(done32), .q_h(q32),
    .q_sio_in_l(q_sio_in_l), .q_sio_out_l(out32)
  );

  alk_qseq #(.DATA_W(64), .CNT_W(7)) dut64 (
    .clk_h(clk_h), .reset_h(reset_h), .dsize_h(dsize_h), .q_load_h(q_load_h),
    .q_load_data_h(ld_data), .start_h(start_h), .dir_shr_h(dir_shr_h),
    .step_cnt_h(step_cnt_h),
`ifdef ALK_QSEQ_ROTATE_EN
    .rot_h(rot_h),
`endif
    .busy_h(busy64), .done_h(done64), .q_h(q64),
    .q_sio_in_l(q_sio_in_l), .q_sio_out_l(out64)
  );

  // ---------------- model: index 0 = 32-bit, 1 = 64-bit ----------------
  int          wdt[2] = '{32, 64};
  logic [63:0] mq[2];
  int          rem[2];
  bit          mdone[2];
  int          msb[2];
  bit          mdir[2];
  bit          mrot[2];

  function automatic int msb_of(int k, logic [1:0] ds);
    case (ds)
      2'b00:   return 7;
      2'b01:   return 15;
      2'b10:   return 31;
      default: return (wdt[k] == 64) ? 63 : 31;
    endcase
  endfunction

  function automatic int tap_of(int m);
    if (m == 7) return 1;
    if (m == 15) return 2;
    if (m == 31) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 64'h0; rem[k] = 0; mdone[k] = 0;
      msb[k] = 7; mdir[k] = 0; mrot[k] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs present at it
  task automatic model_step();
    logic [63:0] nq;
    bit in_b, out_b;
    if (reset_h) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (rem[k] > 0) begin
        nq = mq[k];
        out_b = mdir[k] ? mq[k][0] : mq[k][msb[k]];
        in_b = mrot[k] ? out_b : ~q_sio_in_l[mdir[k] ? tap_of(msb[k]) : 0];
        if (mdir[k]) begin
          for (int i = 0; i < msb[k]; i++) nq[i] = mq[k][i+1];
          nq[msb[k]] = in_b;
        end else begin
          for (int i = 1; i <= msb[k]; i++) nq[i] = mq[k][i-1];
          nq[0] = in_b;
        end
        mq[k] = nq;
        rem[k] = rem[k] - 1;
        mdone[k] = (rem[k] == 0);
      end else if (mdone[k]) begin
        mdone[k] = 0;
      end else begin
        if (q_load_h) mq[k] = (k == 0) ? {32'h0, ld_data[31:0]} : ld_data;
        if (start_h) begin
          msb[k] = msb_of(k, dsize_h);
          mdir[k] = dir_shr_h;
          rem[k] = (step_cnt_h == 0) ? wdt[k] : int'(step_cnt_h);
`ifdef ALK_QSEQ_ROTATE_EN
          mrot[k] = rot_h;
`else
          mrot[k] = 0;
`endif
        end
      end
    end
  endtask

  function automatic logic [4:0] exp_pads(int k);
    logic [4:0] p = 5'b11111;
    int tap;
    if (rem[k] > 0 && !mrot[k]) begin
      tap = mdir[k] ? 0 : tap_of(msb[k]);
      p[tap] = ~(mdir[k] ? mq[k][0] : mq[k][msb[k]]);
    end
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("q32", {32'h0, q32}, mq[0]);
    chk("busy32", busy32, rem[0] > 0);
    chk("done32", done32, mdone[0]);
    chk("pads32", out32, exp_pads(0));
    chk("q64", q64, mq[1]);
    chk("busy64", busy64, rem[1] > 0);
    chk("done64", done64, mdone[1]);
    chk("pads64", out64, exp_pads(1));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk_h);
    model_step();
    @(negedge clk_h);
    compare_all();
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    start_h = 0; q_load_h = 0;
    while ((busy32 || done32 || busy64 || done64) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk("idle_timeout", n, 0);
  endtask

  task automatic issue(logic [63:0] d, logic [1:0] ds, logic dr, logic [6:0] n,
                       logic [4:0] pads);
    ld_data = d; q_load_h = 1; start_h = 1; dsize_h = ds;
    dir_shr_h = dr; step_cnt_h = n; q_sio_in_l = pads;
    cycle();
    q_load_h = 0; start_h = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int nb, nlow, nd32, nd64, it;
    reset_h = 1; dsize_h = 0; q_load_h = 0; ld_data = 0; start_h = 0;
    dir_shr_h = 0; step_cnt_h = 0; q_sio_in_l = 5'b11111; rot_h = 0;
    model_reset();
    cycle();
    cycle();
    chk("reset_q", q32, 32'h0);
    chk("reset_pads", out32, 5'b11111);
    reset_h = 0;
    cycle();

    // Byte left shift, 1 step, shift-in 1 from tap0
    issue(64'h81, 2'b00, 1'b0, 7'd1, 5'b11110);
    chk("t1_busy", busy32, 1'b1);
    chk("t1_tap1_low", out32, 5'b11101);
    cycle();
    chk("t1_done", done32, 1'b1);
    chk("t1_q32", q32, 32'h3);
    chk("t1_q64", q64, 64'h3);
    cycle();
    chk("t1_done_clear", done32, 1'b0);

    // Word right shift, 4 steps, shift-in 0 from tap2
    issue(64'hABCD_8001, 2'b01, 1'b1, 7'd4, 5'b11111);
    chk("t2_tap0_step1", out32, 5'b11110);
    nb = 0; nlow = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy32) begin
        nb++;
        if (!out32[0]) nlow++;
      end
      if (done32) break;
      cycle();
    end
    chk("t2_busy_cycles", nb, 4);
    chk("t2_tap0_low_cycles", nlow, 1);
    chk("t2_q32", q32, 32'hABCD_0800);
    run_until_idle(10);

    // Step count 0 = full width, with an ignored start mid-run
    issue(64'h8000_0000, 2'b10, 1'b1, 7'd0, 5'b11111);
    nb = 0; nd32 = 0; nd64 = 0; it = 0;
    step_cnt_h = 7'd3;
    while ((busy32 || done32 || busy64 || done64) && it < 200) begin
      if (busy32) nb++;
      if (done32) nd32++;
      if (done64) nd64++;
      start_h = (it == 5);
      cycle();
      it++;
    end
    start_h = 0;
    if (it >= 200) chk("t3_timeout", it, 0);
    chk("t3_busy_cycles", nb, 32);
    chk("t3_done32_count", nd32, 1);
    chk("t3_done64_count", nd64, 1);
    chk("t3_q32", q32, 32'h0);
    chk("t3_q64", q64, 64'h0);

    // Quad left shift, 1 step, msb out on tap4
    issue(64'h8000_0000_0000_0000, 2'b11, 1'b0, 7'd1, 5'b11110);
    chk("t4_tap4_low", out64, 5'b01111);
    cycle();
    chk("t4_q64", q64, 64'h1);
    chk("t4_q32", q32, 32'h1);
    cycle();

    // Asynchronous reset in the middle of a run with 10 steps left
    issue(64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 7'd20, 5'b11111);
    repeat (10) cycle();
    reset_h = 1;
    #1;
    chk("t5_q32", q32, 32'h0);
    chk("t5_busy32", busy32, 1'b0);
    chk("t5_pads32", out32, 5'b11111);
    chk("t5_q64", q64, 64'h0);
    model_reset();
    @(negedge clk_h);
    cycle();
    reset_h = 0;
    cycle();
    chk("t5_idle_busy", busy32, 1'b0);

`ifdef ALK_QSEQ_ROTATE_EN
    // Internal rotate of a byte field, pads stay released
    rot_h = 1;
    issue(64'h1234_5601, 2'b00, 1'b1, 7'd1, 5'b00000);
    chk("t6_pads", out32, 5'b11111);
    cycle();
    chk("t6_q32", q32, 32'h1234_5680);
    rot_h = 0;
    run_until_idle(10);
`endif

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      ld_data = {$urandom, $urandom};
      q_load_h = ($urandom_range(0, 3) == 0);
      start_h = ($urandom_range(0, 2) == 0);
      dsize_h = 2'($urandom_range(0, 3));
      dir_shr_h = 1'($urandom_range(0, 1));
      step_cnt_h = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 12));
      q_sio_in_l = 5'($urandom_range(0, 31));
      rot_h = 1'($urandom_range(0, 1));
      cycle();
    end
    run_until_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
